spi_arbiter: RTL and testbench

//  Shares one SPI byte engine between NREQ requesters (CPU Wishbone port, LED-frame DMA, ...).

---
 rtl/spi_arb_pkg.sv | 21 ++
 rtl/spi_arb_rr.sv | 41 ++++
 rtl/spi_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_spi_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and constants for the SPI requester arbiter
//
// Purpose : arbiter FSM state encoding and common widths.
// Ports   : none (package).
// Macro   : none.
package spi_arb_pkg;

    localparam int MAX_NREQ = 8;
    localparam int BYTE_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_START,
        ST_BUSY,
        ST_DONE,
        ST_HOLD,
        ST_GAP
    } arb_state_e;

endpackage

// File: rtl/spi_arb_rr.sv
// rtl/spi_arb_rr.sv - combinational round-robin picker
//
// Purpose : selects the first active request at or after ptr_i, wrapping mod NREQ.
// Ports   : req_i  in  NREQ  request vector
//           ptr_i  in  PW    search start index (always < NREQ)
//           gnt_o  out NREQ  one-hot winner (0 when no request)
//           idx_o  out PW    binary index of winner
//           any_o  out 1     at least one request present
// Macro   : none.
module spi_arb_rr #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin burst arbiter sharing one SPI byte engine
//
// Purpose : grants one requester per burst, owns the chip selects, and sequences
//           start/busy handshakes to the byte engine one byte at a time.
// Ports   : clk, reset (sync, active high)
//           req_i/req_last_i/req_dat_i  requester byte, last flag, tx data
//           gnt_o      one-hot burst owner
//           done_o     1-cycle pulse per completed byte, rdat_o valid
//           rdat_o     rx byte, held until next done_o
//           timeout_o  1-cycle pulse on forced HOLD release
//           eng_start_o/eng_dat_o  start pulse and tx byte to engine
//           eng_busy_i/eng_dat_i   engine busy and rx byte
//           spi_cs_n_o active-low chip selects
// Macro   : SPI_ARB_TIMEOUT_EN enables the HOLD idle timeout (TIMEOUT_CYC).
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int CS_SETUP    = 2,
    parameter int CS_GAP      = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      req_last_i,
    input  logic [8*NREQ-1:0]    req_dat_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      done_o,
    output logic [7:0]           rdat_o,
    output logic                 timeout_o,
    output logic                 eng_start_o,
    output logic [7:0]           eng_dat_o,
    input  logic                 eng_busy_i,
    input  logic [7:0]           eng_dat_i,
    output logic [NREQ-1:0]      spi_cs_n_o
);

    localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_MAX = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'((CS_SETUP > 0) ? CS_SETUP - 1 : 0);
    localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);

    if (NREQ < 1 || NREQ > MAX_NREQ || CS_SETUP < 0 || CS_SETUP > 15 ||
        CS_GAP < 1 || CS_GAP > 15 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("spi_arbiter: parameter out of range");
    end

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]   own_q, own_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;
    logic [7:0]      rdat_q, rdat_d;

    logic [NREQ-1:0] rr_gnt;
    logic [PW-1:0]   rr_idx;
    logic            rr_any;
    logic            own_req;
    logic            cs_active;

    spi_arb_rr #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx),
        .any_o (rr_any)
    );

    assign own_req   = req_i[own_q];
    assign eng_dat_o = req_dat_i[BYTE_W*own_q +: BYTE_W];
    assign gnt_o     = gnt_q;
    assign rdat_o    = rdat_q;

    // CS follows the registered state, so it drops the cycle after the grant
    // and rises the cycle after reset or burst end without extra flops.
    assign cs_active  = (state_q == ST_SELECT) || (state_q == ST_START) ||
                        (state_q == ST_BUSY)   || (state_q == ST_DONE)  ||
                        (state_q == ST_HOLD);
    assign spi_cs_n_o = cs_active ? ~gnt_q : '1;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] idle_q, idle_d;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        own_d       = own_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        rdat_d      = rdat_q;
        eng_start_o = 1'b0;
        done_o      = '0;
        timeout_o   = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        idle_d      = idle_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    gnt_d   = rr_gnt;
                    own_d   = rr_idx;
                    ptr_d   = (rr_idx == PW'(NREQ - 1)) ? '0 : rr_idx + 1'b1;
                    cnt_d   = '0;
                    state_d = (CS_SETUP == 0) ? ST_START : ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_START: begin
                if (!eng_busy_i && own_req) begin
                    eng_start_o = 1'b1;
                    last_d      = req_last_i[own_q];
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Engine raises busy the cycle after start, so the first BUSY
                // cycle never sees a stale low from the previous byte.
                if (!eng_busy_i) begin
                    rdat_d  = eng_dat_i;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o = gnt_q;
`ifdef SPI_ARB_TIMEOUT_EN
                idle_d = '0;
`endif
                if (last_q) begin
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (own_req) begin
                    state_d = ST_START;
`ifdef SPI_ARB_TIMEOUT_EN
                    idle_d  = '0;
                end else if (idle_q == TO_LAST) begin
                    timeout_o = 1'b1;
                    gnt_d     = '0;
                    cnt_d     = '0;
                    state_d   = ST_GAP;
                end else begin
                    idle_d = idle_q + 1'b1;
`endif
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            own_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            rdat_q  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            idle_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            rdat_q  <= rdat_d;
`ifdef SPI_ARB_TIMEOUT_EN
            idle_q  <= idle_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - directed self-checking bench for spi_arbiter
module tb_spi_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_i = '0;
    logic [1:0]  req_last_i = '0;
    logic [15:0] req_dat_i = '0;
    logic [1:0]  gnt_o;
    logic [1:0]  done_o;
    logic [7:0]  rdat_o;
    logic        timeout_o;
    logic        eng_start_o;
    logic [7:0]  eng_dat_o;
    logic        eng_busy_i = 1'b0;
    logic [7:0]  eng_dat_i = '0;
    logic [1:0]  spi_cs_n_o;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    spi_arbiter #(
        .NREQ        (2),
        .CS_SETUP    (2),
        .CS_GAP      (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .req_last_i  (req_last_i),
        .req_dat_i   (req_dat_i),
        .gnt_o       (gnt_o),
        .done_o      (done_o),
        .rdat_o      (rdat_o),
        .timeout_o   (timeout_o),
        .eng_start_o (eng_start_o),
        .eng_dat_o   (eng_dat_o),
        .eng_busy_i  (eng_busy_i),
        .eng_dat_i   (eng_dat_i),
        .spi_cs_n_o  (spi_cs_n_o)
    );

    // Byte engine model: busy for 3 cycles starting the cycle after start,
    // returns tx ^ 0x99 (0xA5 -> 0x3C).
    int bcnt = 0;
    always @(posedge clk) begin
        if (eng_start_o) begin
            eng_busy_i <= 1'b1;
            bcnt       <= 3;
            eng_dat_i  <= eng_dat_o ^ 8'h99;
        end else if (eng_busy_i) begin
            if (bcnt == 1) eng_busy_i <= 1'b0;
            bcnt <= bcnt - 1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_i = '0;
        req_last_i = '0;
        tick; tick;
        reset = 1'b0;
        tick;
    endtask

    // Burst driver: records observations, the scenario tasks judge them.
    int obs_setup, obs_nstart, obs_csbreak, obs_gntbad, obs_datbad, obs_donebad, obs_lat, obs_hang;
    logic [7:0] obs_rdat [3];

    task automatic burst(input int r, input int n, input logic [7:0] b0);
        int k = 0;
        int tstart = 0;
        bit seen_low = 0;
        bit started = 0;
        obs_setup = 0; obs_nstart = 0; obs_csbreak = 0; obs_gntbad = 0;
        obs_datbad = 0; obs_donebad = 0; obs_lat = 0; obs_hang = 0;
        req_dat_i[8*r +: 8] = b0;
        req_last_i[r] = (n == 1);
        req_i[r] = 1'b1;
        for (int cyc = 0; cyc < 300 && k < n; cyc++) begin
            tick;
            if (spi_cs_n_o[r] == 1'b0) begin
                seen_low = 1;
                if (gnt_o !== 2'(1 << r)) obs_gntbad++;
                if (!started && !eng_start_o) obs_setup++;
            end else if (seen_low) begin
                obs_csbreak++;
            end
            if (eng_start_o) begin
                obs_nstart++;
                started = 1;
                tstart = cyc;
                if (eng_dat_o !== b0 + 8'(k)) obs_datbad++;
            end
            if (done_o != 2'b00) begin
                if (done_o !== 2'(1 << r)) obs_donebad++;
                obs_lat = cyc - tstart;
                obs_rdat[k] = rdat_o;
                k++;
                if (k < n) begin
                    req_dat_i[8*r +: 8] = b0 + 8'(k);
                    req_last_i[r] = (k == n - 1);
                end else begin
                    req_i[r] = 1'b0;
                    req_last_i[r] = 1'b0;
                end
            end
        end
        if (k < n) obs_hang = 1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_i = '0;
        tick; tick;
        checks++; if (gnt_o !== 2'b00) $display("FAIL reset_gnt: got %b want 00", gnt_o); else passes++;
        checks++; if (spi_cs_n_o !== 2'b11) $display("FAIL reset_cs: got %b want 11", spi_cs_n_o); else passes++;
        checks++; if (done_o !== 2'b00) $display("FAIL reset_done: got %b want 00", done_o); else passes++;
        checks++; if (eng_start_o !== 1'b0) $display("FAIL reset_start: got %b want 0", eng_start_o); else passes++;
        checks++; if (timeout_o !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout_o); else passes++;
        checks++; if (rdat_o !== 8'h00) $display("FAIL reset_rdat: got %h want 00", rdat_o); else passes++;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_single;
        int bad = 0;
        do_reset;
        burst(0, 1, 8'hA5);
        checks++; if (obs_hang !== 0) $display("FAIL single_hang: got %0d want 0", obs_hang); else passes++;
        checks++; if (obs_setup !== 2) $display("FAIL single_setup: got %0d want 2", obs_setup); else passes++;
        checks++; if (obs_nstart !== 1) $display("FAIL single_starts: got %0d want 1", obs_nstart); else passes++;
        checks++; if (obs_datbad !== 0) $display("FAIL single_engdat: got %0d bad want 0", obs_datbad); else passes++;
        checks++; if (obs_gntbad !== 0) $display("FAIL single_gnt_cs: got %0d bad want 0", obs_gntbad); else passes++;
        checks++; if (obs_donebad !== 0) $display("FAIL single_done: got %0d bad want 0", obs_donebad); else passes++;
        checks++; if (obs_rdat[0] !== 8'h3C) $display("FAIL single_rdat: got %h want 3c", obs_rdat[0]); else passes++;
        checks++; if (obs_lat !== 5) $display("FAIL single_latency: got %0d want 5", obs_lat); else passes++;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (spi_cs_n_o !== 2'b11 || gnt_o !== 2'b00) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL single_gap: got %0d bad cycles want 0", bad); else passes++;
    endtask

    task automatic test_simultaneous;
        do_reset;
        req_dat_i = 16'h2211;
        req_last_i = 2'b11;
        req_i = 2'b11;
        for (int i = 0; i < 50; i++) begin tick; if (gnt_o != 2'b00) break; end
        checks++; if (gnt_o !== 2'b01) $display("FAIL simul_first_gnt: got %b want 01", gnt_o); else passes++;
        for (int i = 0; i < 100; i++) begin tick; if (done_o != 2'b00) break; end
        checks++; if (done_o !== 2'b01 || rdat_o !== 8'h88) $display("FAIL simul_first_done: got %b/%h want 01/88", done_o, rdat_o); else passes++;
        req_i[0] = 1'b0;
        for (int i = 0; i < 100; i++) begin tick; if (gnt_o != 2'b00) break; end
        checks++; if (gnt_o !== 2'b10) $display("FAIL simul_second_gnt: got %b want 10", gnt_o); else passes++;
        for (int i = 0; i < 100; i++) begin tick; if (done_o != 2'b00) break; end
        checks++; if (done_o !== 2'b10 || rdat_o !== 8'hBB) $display("FAIL simul_second_done: got %b/%h want 10/bb", done_o, rdat_o); else passes++;
        req_i = '0;
        req_last_i = '0;
    endtask

    task automatic test_multi;
        burst(1, 3, 8'h01);
        checks++; if (obs_hang !== 0 || obs_nstart !== 3) $display("FAIL multi_starts: got %0d (hang %0d) want 3", obs_nstart, obs_hang); else passes++;
        checks++; if (obs_csbreak !== 0 || obs_gntbad !== 0) $display("FAIL multi_cs_held: got %0d breaks %0d bad want 0", obs_csbreak, obs_gntbad); else passes++;
        checks++; if (obs_datbad !== 0 || obs_donebad !== 0) $display("FAIL multi_bytes: got %0d/%0d bad want 0", obs_datbad, obs_donebad); else passes++;
        checks++; if (obs_rdat[0] !== 8'h98 || obs_rdat[1] !== 8'h9B || obs_rdat[2] !== 8'h9A)
            $display("FAIL multi_rdat: got %h %h %h want 98 9b 9a", obs_rdat[0], obs_rdat[1], obs_rdat[2]); else passes++;
        tick;
        checks++; if (spi_cs_n_o !== 2'b11) $display("FAIL multi_release: got %b want 11", spi_cs_n_o); else passes++;
    endtask

    task automatic test_contention;
        int nd0 = 0;
        int early = 0;
        int gapc = 0;
        bit after = 0;
        do_reset;
        req_dat_i[7:0] = 8'h40;
        req_last_i[0] = 1'b0;
        req_i[0] = 1'b1;
        for (int i = 0; i < 50; i++) begin tick; if (gnt_o != 2'b00) break; end
        req_dat_i[15:8] = 8'h50;
        req_last_i[1] = 1'b1;
        req_i[1] = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick;
            if (gnt_o[1] && nd0 < 2) early++;
            if (done_o[0]) begin
                nd0++;
                if (nd0 == 1) begin
                    req_dat_i[7:0] = 8'h41;
                    req_last_i[0] = 1'b1;
                end else begin
                    req_i[0] = 1'b0;
                    req_last_i[0] = 1'b0;
                    after = 1;
                end
            end else if (after) begin
                if (spi_cs_n_o == 2'b11) gapc++;
                else break;
            end
        end
        checks++; if (early !== 0 || nd0 !== 2) $display("FAIL contend_no_preempt: got early %0d done %0d want 0/2", early, nd0); else passes++;
        checks++; if (gapc !== 5) $display("FAIL contend_gap: got %0d want 5", gapc); else passes++;
        checks++; if (spi_cs_n_o !== 2'b01 || gnt_o !== 2'b10) $display("FAIL contend_next_gnt: got %b/%b want 01/10", spi_cs_n_o, gnt_o); else passes++;
        for (int i = 0; i < 100; i++) begin tick; if (done_o != 2'b00) break; end
        checks++; if (done_o !== 2'b10 || rdat_o !== 8'hC9) $display("FAIL contend_req1_done: got %b/%h want 10/c9", done_o, rdat_o); else passes++;
        req_i = '0;
        req_last_i = '0;
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int n = 0;
        do_reset;
        req_dat_i[7:0] = 8'h10;
        req_last_i[0] = 1'b0;
        req_i[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin tick; if (done_o[0]) break; end
        req_i[0] = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            tick;
            if (timeout_o) begin n = i; break; end
        end
        checks++; if (n !== 8) $display("FAIL timeout_cycles: got %0d want 8", n); else passes++;
        tick;
        checks++; if (spi_cs_n_o !== 2'b11 || gnt_o !== 2'b00) $display("FAIL timeout_release: got %b/%b want 11/00", spi_cs_n_o, gnt_o); else passes++;
    endtask
`else
    task automatic test_hold;
        int nto = 0;
        int nhigh = 0;
        do_reset;
        req_dat_i[7:0] = 8'h10;
        req_last_i[0] = 1'b0;
        req_i[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin tick; if (done_o[0]) break; end
        req_i[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (timeout_o) nto++;
            if (spi_cs_n_o[0]) nhigh++;
        end
        checks++; if (nto !== 0 || nhigh !== 0) $display("FAIL hold_wait: got to %0d cs_high %0d want 0/0", nto, nhigh); else passes++;
        req_dat_i[7:0] = 8'h11;
        req_last_i[0] = 1'b1;
        req_i[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin tick; if (done_o[0]) break; end
        checks++; if (done_o !== 2'b01 || rdat_o !== 8'h88) $display("FAIL hold_resume: got %b/%h want 01/88", done_o, rdat_o); else passes++;
        req_i = '0;
        req_last_i = '0;
        tick;
        checks++; if (spi_cs_n_o !== 2'b11) $display("FAIL hold_release: got %b want 11", spi_cs_n_o); else passes++;
    endtask
`endif

    task automatic test_reset_busy;
        int nd = 0;
        do_reset;
        req_dat_i[7:0] = 8'h77;
        req_last_i[0] = 1'b1;
        req_i[0] = 1'b1;
        for (int i = 0; i < 50; i++) begin tick; if (eng_start_o) break; end
        tick;
        reset = 1'b1;
        tick;
        checks++; if (spi_cs_n_o !== 2'b11 || gnt_o !== 2'b00 || done_o !== 2'b00)
            $display("FAIL rstbusy_state: got cs %b gnt %b done %b want 11/00/00", spi_cs_n_o, gnt_o, done_o); else passes++;
        req_i = '0;
        req_last_i = '0;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin tick; if (done_o != 2'b00) nd++; end
        checks++; if (nd !== 0) $display("FAIL rstbusy_no_done: got %0d want 0", nd); else passes++;
    endtask

    initial begin
        test_reset;
        test_single;
        test_simultaneous;
        test_multi;
        test_contention;
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout;
`else
        test_hold;
`endif
        test_reset_busy;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
